// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and constants for the memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic [31:0] POISON = 32'hDEADBEEF;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word RAM, one-cycle registered read.
// Ports: clk, rst_n (async active-low, clears read register only),
// re_i/we_i enables, addr_i word index, wdata_i store data, rdata_o read data.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave for the multicycle CPU.
// Ports: clk, rst (async active-low), mem_read/mem_write level-held requests,
// addr byte address, wdata store data, rdata registered read data,
// ready one-cycle completion pulse, busy access in flight, err misalignment.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses flag err,
// writes are dropped and reads return the poison word).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY == 0 ? 0 : LATENCY - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdat_q, wdat_d, arr_rdata;
  logic wr_q, wr_d, mis_q, mis_d, psn_q, psn_d;
  logic accept, go, mis_in, we, re, unused;
  assign unused = ^{addr[31:AW+2], addr[1:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in = |addr[1:0];
`else
  assign mis_in = 1'b0;
`endif
  assign accept = state_q == IDLE && (mem_read || mem_write);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == DONE ? IDLE :
              state_q == WAIT ? (cnt_q == '0 ? DONE : WAIT) :
              accept ? (LATENCY == 0 ? DONE : WAIT) : IDLE;
  always_comb begin
    ready = state_q == DONE;
    busy  = state_q != IDLE;
`ifdef MEM_ALIGN_CHECK_EN
    err   = ready && mis_q;
`else
    err   = 1'b0;
`endif
  end
  // The access description bypasses its latches at acceptance so that a
  // zero-latency access can hit the array on the acceptance edge itself.
  always_comb begin
    idx_d  = accept ? addr[AW+1:2] : idx_q;
    wdat_d = accept ? wdata : wdat_q;
    wr_d   = accept ? mem_write : wr_q;
    mis_d  = accept ? mis_in : mis_q;
    cnt_d  = accept ? CNT_INIT : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    go     = state_d == DONE;
    we     = go && wr_d && !mis_d;
    re     = go && !wr_d && !mis_d;
    psn_d  = (go && !wr_d) ? mis_d : psn_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wdat_q <= '0;
      wr_q   <= 1'b0;
      mis_q  <= 1'b0;
      psn_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wdat_q <= wdat_d;
      wr_q   <= wr_d;
      mis_q  <= mis_d;
      psn_q  <= psn_d;
    end
  mem_array #(.DEPTH(DEPTH_WORDS)) u_arr (
    .clk    (clk),
    .rst_n  (rst),
    .re_i   (re),
    .we_i   (we),
    .addr_i (idx_d),
    .wdata_i(wdat_d),
    .rdata_o(arr_rdata)
  );
  assign rdata = psn_q ? POISON : arr_rdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder at LATENCY 2 and 0.
module tb_mem_responder;
  logic clk = 0, rst_n = 0;
  logic [1:0] rd = '0, wr = '0, rdy, bsy, er;
  logic [31:0] ad [2] = '{32'h0, 32'h0};
  logic [31:0] wd [2] = '{32'h0, 32'h0};
  logic [1:0][31:0] rdo;
  int checks = 0, errors = 0;
  int lat [2] = '{2, 0};

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst_n), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdo[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0]));
  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u1 (
    .clk(clk), .rst(rst_n), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdo[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timestamp model: an access accepted at edge n completes at edge n+L,
  // is busy for the cycles after edges n..n+L, and frees the slave at n+L+2.
  int cyc = 0;
  bit pend [2] = '{0, 0};
  bit mwr [2], mmis [2];
  int acc [2], dn [2], midx [2];
  logic [31:0] mwd [2];
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic [31:0] mm [int];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0;
        exp_rd[k] = 32'h0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if ((!pend[k] || cyc > dn[k] + 1) && (rd[k] || wr[k])) begin
          pend[k] = 1;
          acc[k] = cyc;
          dn[k] = cyc + lat[k];
          mwr[k] = wr[k];
          midx[k] = int'(ad[k] >> 2) % 256;
          mwd[k] = wd[k];
`ifdef MEM_ALIGN_CHECK_EN
          mmis[k] = ad[k][1:0] != 2'b00;
`else
          mmis[k] = 0;
`endif
        end
        if (pend[k] && cyc == dn[k]) begin
          if (mwr[k]) begin
            if (!mmis[k]) mm[k * 1024 + midx[k]] = mwd[k];
          end else exp_rd[k] = mmis[k] ? 32'hDEADBEEF : mm[k * 1024 + midx[k]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic r, b;
      r = pend[k] && cyc == dn[k];
      b = pend[k] && cyc >= acc[k] && cyc <= dn[k];
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(r));
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(b));
      chk($sformatf("err%0d", k), 32'(er[k]), 32'(r && mmis[k]));
      chk($sformatf("rdata%0d", k), rdo[k], exp_rd[k]);
    end
  end

  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rq, output logic e, output int n);
    @(negedge clk);
    #1;
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[k] && n < 40);
    if (!rdy[k]) chk("ready_timeout", 32'(0), 32'(1));
    rq = rdo[k];
    e = er[k];
    @(posedge clk);
    #1;
    rd[k] = 0; wr[k] = 0;
  endtask

  initial begin
    logic [31:0] q;
    logic e;
    int n, cnt;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdo[0], 32'h0);
    chk("rst_busy", 32'(bsy[0]), 32'h0);
    #1 rst_n = 1;
    access(0, 0, 1, 32'h10, 32'h12345678, q, e, n);
    chk("lat_wr", n, 3);
    access(0, 1, 0, 32'h10, 32'h0, q, e, n);
    chk("lat_rd", n, 3);
    chk("rd_10", q, 32'h12345678);
    access(0, 1, 1, 32'h20, 32'hA5A5A5A5, q, e, n);
    chk("rw_keep", q, 32'h12345678);
    access(0, 1, 0, 32'h20, 32'h0, q, e, n);
    chk("rd_20", q, 32'hA5A5A5A5);
    access(0, 0, 1, 32'h400, 32'hCAFEF00D, q, e, n);
    access(0, 1, 0, 32'h000, 32'h0, q, e, n);
    chk("wrap", q, 32'hCAFEF00D);
    access(0, 0, 1, 32'h30, 32'h11112222, q, e, n);
    @(negedge clk);
    #1 wr[0] = 1; ad[0] = 32'h30; wd[0] = 32'h33334444;
    repeat (2) @(negedge clk);
    chk("mid_wait_busy", 32'(bsy[0]), 32'h1);
    #1 rst_n = 0;
    @(negedge clk);
    chk("abort_ready", 32'(rdy[0]), 32'h0);
    chk("abort_rdata", rdo[0], 32'h0);
    #1 wr[0] = 0;
    @(negedge clk);
    #1 rst_n = 1;
    access(0, 1, 0, 32'h30, 32'h0, q, e, n);
    chk("abort_keep", q, 32'h11112222);
    access(0, 1, 0, 32'h13, 32'h0, q, e, n);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_rd_err", 32'(e), 32'h1);
    chk("mis_rd_data", q, 32'hDEADBEEF);
`else
    chk("mis_rd_err", 32'(e), 32'h0);
    chk("mis_rd_data", q, 32'h12345678);
`endif
    chk("mis_lat", n, 3);
    access(0, 0, 1, 32'h11, 32'h55AA55AA, q, e, n);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_wr_err", 32'(e), 32'h1);
    access(0, 1, 0, 32'h10, 32'h0, q, e, n);
    chk("mis_wr_keep", q, 32'h12345678);
`else
    chk("mis_wr_err", 32'(e), 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, q, e, n);
    chk("mis_wr_keep", q, 32'h55AA55AA);
`endif
    access(1, 0, 1, 32'h40, 32'h0BADF00D, q, e, n);
    chk("lat0_wr", n, 1);
    @(negedge clk);
    #1 rd[1] = 1; ad[1] = 32'h40;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[1]) begin
        cnt++;
        chk("b2b_data", rdo[1], 32'h0BADF00D);
      end
    end
    #1 rd[1] = 0;
    chk("b2b_count", cnt, 3);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
